// File: rtl/pdu_dmem_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter and a shared
// single-port data memory.
//   mN_req/we/addr/wdata : request from master N (held until mN_gnt)
//   mN_gnt / mN_rvalid   : one-cycle accept / completion pulses
//   mN_rdata             : read data (write data on a write), held
//   mem_addr/wdata/we    : memory command, mem_rdata : registered read data
//   busy                 : arbiter has a transaction in flight
// Modport slave is the arbiter side, master is the environment side.
interface pdu_dmem_arbiter_if #(
  parameter int DEPTH = 12
) ();
  logic             m0_req;
  logic             m0_we;
  logic [DEPTH-1:0] m0_addr;
  logic [31:0]      m0_wdata;
  logic             m0_gnt;
  logic             m0_rvalid;
  logic [31:0]      m0_rdata;

  logic             m1_req;
  logic             m1_we;
  logic [DEPTH-1:0] m1_addr;
  logic [31:0]      m1_wdata;
  logic             m1_gnt;
  logic             m1_rvalid;
  logic [31:0]      m1_rdata;

  logic [DEPTH-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic [31:0]      mem_rdata;
  logic             busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/pdu_dmem_arbiter.sv
// Two-master round-robin arbiter in front of a shared data memory with a
// one-cycle registered read. One transaction every 3 cycles at most:
//   IDLE  : sample requests, latch winner's payload, grant
//   ISSUE : memory command driven (gnt high, mem_we high for writes)
//   RESP  : memory data available, loaded into winner's rdata at exit
// Ports: sys_clk, sys_rst_n (synchronous, active-low), bus (slave modport).
module pdu_dmem_arbiter #(
  parameter int DEPTH = 12
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  pdu_dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             any_req_s;
  logic             win_s;
  logic             win_r;
  logic             last_r;     // master granted last; reset to 1 so m0 wins first tie
  logic             we_r;
  logic [DEPTH-1:0] addr_r;
  logic [31:0]      wdata_r;
  logic             rvalid0_r;
  logic             rvalid1_r;
  logic [31:0]      rdata0_r;
  logic [31:0]      rdata1_r;

  // Request arbitration: single requester wins, ties go to the other-than-last master
  always_comb begin
    any_req_s = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      win_s = ~last_r;
    end else if (bus.m1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; ISSUE and RESP always advance, requests ignored there
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = any_req_s ? ISSUE : IDLE;
      ISSUE:   state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Payload latch on grant, and per-master completion registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      win_r     <= 1'b0;
      last_r    <= 1'b1;
      we_r      <= 1'b0;
      addr_r    <= {DEPTH{1'b0}};
      wdata_r   <= 32'h0000_0000;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= 32'h0000_0000;
      rdata1_r  <= 32'h0000_0000;
    end else begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      if (state_r == IDLE && any_req_s) begin
        win_r   <= win_s;
        last_r  <= win_s;
        we_r    <= win_s ? bus.m1_we    : bus.m0_we;
        addr_r  <= win_s ? bus.m1_addr  : bus.m0_addr;
        wdata_r <= win_s ? bus.m1_wdata : bus.m0_wdata;
      end
      // Memory echoes write data on writes, so both access kinds complete here
      if (state_r == RESP) begin
        if (win_r) begin
          rdata1_r  <= bus.mem_rdata;
          rvalid1_r <= 1'b1;
        end else begin
          rdata0_r  <= bus.mem_rdata;
          rvalid0_r <= 1'b1;
        end
      end
    end
  end

  // Output decode from registered state; gnt is high exactly during ISSUE
  always_comb begin
    bus.m0_gnt = (state_r == ISSUE) && !win_r;
    bus.m1_gnt = (state_r == ISSUE) &&  win_r;
    bus.mem_we = (state_r == ISSUE) &&  we_r;
    bus.busy   = (state_r != IDLE);
  end

  assign bus.m0_rvalid = rvalid0_r;
  assign bus.m1_rvalid = rvalid1_r;
  assign bus.m0_rdata  = rdata0_r;
  assign bus.m1_rdata  = rdata1_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;

endmodule

// File: doc/pdu_dmem_arbiter.md
PDU_DMEM_ARBITER -- requirements
Module: pdu_dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 12, SHALL set the word-address width of the shared data memory.
REQ-002 sys_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 sys_rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 mN_req  input  1  (N=0,1) SHALL request one memory access.
REQ-005 mN_we  input  1  SHALL mark the request as a write (1) or a read (0).
REQ-006 mN_addr  input  DEPTH  SHALL be the word address of the request.
REQ-007 mN_wdata  input  32  SHALL be the write data of the request.
REQ-008 mN_gnt  output  1  SHALL be a one-cycle pulse: request accepted.
REQ-009 mN_rvalid  output  1  SHALL be a one-cycle pulse: access complete, mN_rdata valid.
REQ-010 mN_rdata  output  32  SHALL carry the read data, held until the next completion for master N.
REQ-011 mem_addr  output  DEPTH  SHALL drive the memory address.
REQ-012 mem_wdata  output  32  SHALL drive the memory write data.
REQ-013 mem_we  output  1  SHALL drive the memory write enable.
REQ-014 mem_rdata  input  32  SHALL be the registered memory read data, with 1-cycle latency; on a write it returns the write data.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-017 In IDLE with any mN_req high at an edge, the block SHALL latch that master's we/addr/wdata and its index, set mN_gnt=1, and move to ISSUE.
REQ-018 In IDLE with no request, the FSM SHALL stay in IDLE and all pulses SHALL be 0.
REQ-019 In ISSUE, mem_addr, mem_wdata and mem_we SHALL equal the latched values; the next edge SHALL move the FSM to RESP and clear gnt.
REQ-020 mem_we SHALL be 1 only in the ISSUE cycle of a write; in all other cycles mem_we=0 and mem_addr/mem_wdata SHALL hold their last latched values.
REQ-021 At the edge leaving RESP, the block SHALL load mem_rdata into the winning master's mN_rdata, pulse mN_rvalid=1 for one cycle, and return to IDLE.
REQ-022 Writes SHALL also complete with mN_rvalid, and mN_rdata SHALL then equal the written data.
REQ-023 Latency SHALL be fixed: gnt one cycle after the sampling edge, rvalid two cycles after gnt, giving one transaction per 3 cycles at most.
REQ-024 Requests SHALL be ignored in ISSUE and RESP; a requester holds req and its payload until it sees gnt, and a req still high when the FSM is back in IDLE SHALL start a new transaction.
REQ-025 If only one master requests, that master SHALL win.
REQ-026 If both masters request in the same IDLE edge, the master not granted last SHALL win (round-robin); after reset m0 SHALL win the first tie.
REQ-027 The last-winner pointer SHALL update only on a grant.
REQ-028 The non-winning master's gnt, rvalid and rdata SHALL be unaffected by the transaction.
REQ-029 Address values SHALL pass through unchanged with no range checking; all DEPTH bits SHALL be valid, including address 2^DEPTH-1.

Reset
REQ-030 With sys_rst_n=0 at an edge, the block SHALL set: state=IDLE, all gnt/rvalid=0, all rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, last-winner pointer so that m0 wins the next tie.
REQ-031 A reset during ISSUE or RESP SHALL abort the transaction with no rvalid pulse; mem_we SHALL be 0 from the reset edge onward.

Verification
REQ-032 m0 writes addr 0x010, data 0xDEADBEEF -> m0_gnt at cycle+1; mem_we=1 with addr 0x010 at cycle+1; m0_rvalid at cycle+3 with m0_rdata=0xDEADBEEF.
REQ-033 m1 reads 0x010 after REQ-032 -> m1_rvalid at cycle+3 with m1_rdata=0xDEADBEEF; m0_rdata unchanged.
REQ-034 Both masters hold req continuously from reset -> grant order m0,m1,m0,m1; each grant 3 cycles apart.
REQ-035 m0 write 0xFFF/0x12345678 at the address boundary, then read 0xFFF -> read data 0x12345678; mem_we high only in the ISSUE cycles.
REQ-036 sys_rst_n=0 in the RESP cycle of a read -> no rvalid; all outputs 0; the next tie is granted to m0.
